// File: rtl/core_dispatch_queue.sv
// In-order N-wide dispatch queue between decode and execute.
// Circular buffer of DEPTH entries; issues the cleared in-order
// prefix of the oldest ISSUE_W entries as registered start pulses.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   flush          drop all entries and cancel this cycle's issue
//   in_valid/data  up to FETCH_W decoded slots (slot 0 oldest)
//   in_ready/stall room for a full FETCH_W group / its inverse
//   peek_valid/data oldest ISSUE_W entries for hazard checking
//   issue_ok       per-peek-slot hazard verdict
//   iss_valid/data registered issue pulses and payloads
//   occupancy      current entry count
module core_dispatch_queue #(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [FETCH_W-1:0]          in_valid,
    input  logic [FETCH_W*DATA_W-1:0]   in_data,
    output logic                        in_ready,
    output logic                        stall,
    output logic [ISSUE_W-1:0]          peek_valid,
    output logic [ISSUE_W*DATA_W-1:0]   peek_data,
    input  logic [ISSUE_W-1:0]          issue_ok,
    output logic [ISSUE_W-1:0]          iss_valid,
    output logic [ISSUE_W*DATA_W-1:0]   iss_data,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < FETCH_W || DEPTH < ISSUE_W) begin : g_bad_depth
        $error("core_dispatch_queue: DEPTH must be >= FETCH_W and ISSUE_W");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [ISSUE_W-1:0] w_fire;
    int                 w_n_in;
    int                 w_n_out;
    logic               w_accept;

    // Modulo-DEPTH pointer add; k never exceeds DEPTH so one
    // conditional subtract is enough, also for non-power-of-2 DEPTH.
    function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] p,
                                             input int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign in_ready  = (int'(r_count) + FETCH_W) <= DEPTH;
    assign stall     = !in_ready;
    assign occupancy = r_count;
    assign w_accept  = in_ready && !flush;

    // Only the leading run of valid slots is taken.
    always_comb begin
        logic run;
        run    = 1'b1;
        w_n_in = 0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (run && in_valid[i]) w_n_in = w_n_in + 1;
            else                    run    = 1'b0;
        end
    end

    always_comb begin
        peek_valid = '0;
        peek_data  = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            peek_valid[i] = int'(r_count) > i;
            peek_data[i*DATA_W +: DATA_W] = r_mem[f_wrap(r_head, i)];
        end
    end

    // A blocked slot blocks every younger slot.
    always_comb begin
        logic prev;
        prev    = 1'b1;
        w_fire  = '0;
        w_n_out = 0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_fire[i] = prev && peek_valid[i] && issue_ok[i];
            prev      = w_fire[i];
            if (w_fire[i]) w_n_out = w_n_out + 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (i < w_n_in)
                    r_mem[f_wrap(r_tail, i)] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            iss_valid <= '0;
            iss_data  <= '0;
        end else if (flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            iss_valid <= '0;
        end else begin
            if (w_accept) r_tail <= f_wrap(r_tail, w_n_in);
            r_head    <= f_wrap(r_head, w_n_out);
            r_count   <= CW'(int'(r_count)
                           + (w_accept ? w_n_in : 0) - w_n_out);
            iss_valid <= w_fire;
            for (int i = 0; i < ISSUE_W; i++) begin
                if (w_fire[i])
                    iss_data[i*DATA_W +: DATA_W] <=
                        peek_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_core_dispatch_queue.sv
// Directed self-checking bench for core_dispatch_queue
// with default parameters (2-wide, depth 4, 32-bit payload).
module tb_core_dispatch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        stall;
    logic [1:0]  peek_valid;
    logic [63:0] peek_data;
    logic [1:0]  issue_ok;
    logic [1:0]  iss_valid;
    logic [63:0] iss_data;
    logic [2:0]  occupancy;

    int n_pass = 0;
    int n_total = 0;

    core_dispatch_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall(stall),
        .peek_valid(peek_valid), .peek_data(peek_data),
        .issue_ok(issue_ok),
        .iss_valid(iss_valid), .iss_data(iss_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 2'b00;
        in_data  = '0;
        issue_ok = 2'b00;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 2'b11; in_data = {32'h11, 32'h10};
        tick();
        in_valid = 2'b01; in_data = {32'h0, 32'h12};
        tick();
        in_valid = 2'b00;
        n_total++;
        if (occupancy !== 3'd3) $display("FAIL pre_reset_occ: got %0d want 3", occupancy);
        else n_pass++;
        rst = 1'b1; in_valid = 2'b11; issue_ok = 2'b11;
        tick();
        rst = 1'b0; in_valid = 2'b00; issue_ok = 2'b00;
        for (int c = 0; c < 3; c++) begin
            n_total++;
            if ({occupancy, peek_valid, iss_valid, in_ready, stall} !== {3'd0, 2'b00, 2'b00, 1'b1, 1'b0})
                $display("FAIL reset_state[%0d]: got occ=%0d pv=%b iv=%b rdy=%b st=%b want 0 00 00 1 0",
                         c, occupancy, peek_valid, iss_valid, in_ready, stall);
            else n_pass++;
            tick();
        end
        n_total++;
        if (iss_data !== 64'h0) $display("FAIL reset_iss_data: got %h want 0", iss_data);
        else n_pass++;
    endtask

    task automatic test_latency();
        idle_inputs();
        in_valid = 2'b11; in_data = {32'hA1, 32'hA0}; issue_ok = 2'b11;
        tick();
        in_valid = 2'b00;
        n_total++;
        if ({peek_valid, iss_valid} !== {2'b11, 2'b00})
            $display("FAIL lat_peek: got pv=%b iv=%b want 11 00", peek_valid, iss_valid);
        else n_pass++;
        n_total++;
        if (peek_data !== {32'hA1, 32'hA0}) $display("FAIL lat_peek_data: got %h want %h", peek_data, {32'hA1, 32'hA0});
        else n_pass++;
        tick();
        n_total++;
        if ({iss_valid, occupancy} !== {2'b11, 3'd0})
            $display("FAIL lat_issue: got iv=%b occ=%0d want 11 0", iss_valid, occupancy);
        else n_pass++;
        n_total++;
        if (iss_data !== {32'hA1, 32'hA0}) $display("FAIL lat_iss_data: got %h want %h", iss_data, {32'hA1, 32'hA0});
        else n_pass++;
        tick();
        n_total++;
        if (iss_valid !== 2'b00) $display("FAIL lat_pulse: got %b want 00", iss_valid);
        else n_pass++;
        issue_ok = 2'b00;
    endtask

    task automatic test_blocking();
        idle_inputs();
        in_valid = 2'b11; in_data = {32'hB1, 32'hB0};
        tick();
        in_valid = 2'b01; in_data = {32'hFF, 32'hB2};
        tick();
        in_valid = 2'b00; issue_ok = 2'b10;
        tick();
        n_total++;
        if ({iss_valid, occupancy} !== {2'b00, 3'd3})
            $display("FAIL blk_slot0: got iv=%b occ=%0d want 00 3", iss_valid, occupancy);
        else n_pass++;
        issue_ok = 2'b01;
        tick();
        n_total++;
        if ({iss_valid, occupancy} !== {2'b01, 3'd2})
            $display("FAIL blk_one: got iv=%b occ=%0d want 01 2", iss_valid, occupancy);
        else n_pass++;
        n_total++;
        if ({iss_data[31:0], peek_data[31:0]} !== {32'hB0, 32'hB1})
            $display("FAIL blk_data: got iss=%h peek=%h want b0 b1", iss_data[31:0], peek_data[31:0]);
        else n_pass++;
        issue_ok = 2'b11;
        tick();
        n_total++;
        if ({iss_valid, iss_data, occupancy} !== {2'b11, 32'hB2, 32'hB1, 3'd0})
            $display("FAIL blk_drain: got iv=%b d=%h occ=%0d want 11 b2b1 0", iss_valid, iss_data, occupancy);
        else n_pass++;
        issue_ok = 2'b00;
        tick();
    endtask

    task automatic test_full();
        idle_inputs();
        in_valid = 2'b11; in_data = {32'hC1, 32'hC0};
        tick();
        in_data = {32'hC3, 32'hC2};
        tick();
        n_total++;
        if ({occupancy, in_ready, stall} !== {3'd4, 1'b0, 1'b1})
            $display("FAIL full_flags: got occ=%0d rdy=%b st=%b want 4 0 1", occupancy, in_ready, stall);
        else n_pass++;
        in_data = {32'hE1, 32'hE0};
        tick();
        n_total++;
        if (occupancy !== 3'd4) $display("FAIL full_ignore: got occ=%0d want 4", occupancy);
        else n_pass++;
        in_valid = 2'b00; issue_ok = 2'b11;
        tick();
        issue_ok = 2'b00;
        n_total++;
        if ({iss_valid, iss_data, occupancy, in_ready, stall} !== {2'b11, 32'hC1, 32'hC0, 3'd2, 1'b1, 1'b0})
            $display("FAIL full_issue: got iv=%b d=%h occ=%0d rdy=%b st=%b want 11 c1c0 2 1 0",
                     iss_valid, iss_data, occupancy, in_ready, stall);
        else n_pass++;
        issue_ok = 2'b11;
        tick();
        n_total++;
        if ({iss_valid, iss_data, occupancy} !== {2'b11, 32'hC3, 32'hC2, 3'd0})
            $display("FAIL full_drain: got iv=%b d=%h occ=%0d want 11 c3c2 0", iss_valid, iss_data, occupancy);
        else n_pass++;
        issue_ok = 2'b00;
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] lo;
        idle_inputs();
        issue_ok = 2'b11;
        for (int c = 0; c < 12; c++) begin
            if (c < 10) begin
                lo = 32'h100 + 32'(2 * c);
                in_valid = 2'b11;
                in_data  = {lo + 32'h1, lo};
            end else begin
                in_valid = 2'b00;
            end
            tick();
            if (c >= 1 && c <= 10) begin
                lo = 32'h100 + 32'(2 * (c - 1));
                n_total++;
                if ({iss_valid, iss_data} !== {2'b11, lo + 32'h1, lo})
                    $display("FAIL wrap[%0d]: got iv=%b d=%h want 11 %h", c, iss_valid, iss_data, {lo + 32'h1, lo});
                else n_pass++;
            end else begin
                n_total++;
                if (iss_valid !== 2'b00) $display("FAIL wrap_idle[%0d]: got %b want 00", c, iss_valid);
                else n_pass++;
            end
        end
        n_total++;
        if (occupancy !== 3'd0) $display("FAIL wrap_occ: got %0d want 0", occupancy);
        else n_pass++;
        issue_ok = 2'b00;
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 2'b11; in_data = {32'hF1, 32'hF0};
        tick();
        in_valid = 2'b11; in_data = {32'hD1, 32'hD0};
        issue_ok = 2'b11; flush = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready);
        else n_pass++;
        tick();
        flush = 1'b0; in_valid = 2'b00;
        n_total++;
        if ({iss_valid, occupancy, peek_valid} !== {2'b00, 3'd0, 2'b00})
            $display("FAIL flush_state: got iv=%b occ=%0d pv=%b want 00 0 00", iss_valid, occupancy, peek_valid);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if ({iss_valid, occupancy} !== {2'b00, 3'd0})
                $display("FAIL flush_quiet[%0d]: got iv=%b occ=%0d want 00 0", c, iss_valid, occupancy);
            else n_pass++;
        end
        issue_ok = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_latency();
        test_blocking();
        test_full();
        test_wrap();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/core_dispatch_queue.md
Name: core_dispatch_queue

Overview:
- Parametrised, in-order, N-wide dispatch buffer. It replaces the fixed dual-issue hold register with a circular queue of DEPTH entries.
- Sits between decode and the execution units:
  - accepts up to FETCH_W decoded instructions per cycle;
  - presents the oldest ISSUE_W entries for hazard checking;
  - issues the longest in-order prefix cleared by the hazard logic as registered start pulses.
- Payload is opaque (DATA_W bits). Callers pack insn_decode into it.

Parameters:
- FETCH_W, 2, instructions offered per cycle by decode.
- ISSUE_W, 2, maximum instructions issued per cycle.
- DEPTH, 4, queue entries. Legal only if DEPTH >= FETCH_W and DEPTH >= ISSUE_W; otherwise elaboration error.
- DATA_W, 32, payload width per instruction.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued entries and cancel the issue that would otherwise register this cycle.
- in_valid  in  FETCH_W  per-slot valid from decode; slot 0 is oldest.
- in_data  in  FETCH_W*DATA_W  slot i at bits [i*DATA_W +: DATA_W].
- in_ready  out  1  queue can take a full FETCH_W group this cycle.
- stall  out  1  equals !in_ready (decode hold).
- peek_valid  out  ISSUE_W  entry head+i exists.
- peek_data  out  ISSUE_W*DATA_W  entry head+i (mod DEPTH); combinational from state.
- issue_ok  in  ISSUE_W  external hazard verdict for peek slot i; sampled the same cycle.
- iss_valid  out  ISSUE_W  registered one-cycle start pulse per issue slot.
- iss_data  out  ISSUE_W*DATA_W  registered payload accompanying iss_valid.
- occupancy  out  $clog2(DEPTH+1)  current entry count.

Behaviour:
- State: head, tail (each $clog2(DEPTH) bits, wrap modulo DEPTH, also for non-power-of-2 DEPTH), count (0..DEPTH), entry array.
- in_ready = (DEPTH - count) >= FETCH_W, using current count only. Same-cycle issues do not free space for the same-cycle enqueue.
- Enqueue count n_in = length of the leading run of ones in in_valid; bits after the first zero are ignored.
  - Accepted only when in_ready && !flush && !rst.
  - Entries are written at tail, tail+1, … in slot order; tail advances by n_in.
- peek_valid[i] = (count > i); peek_data[i] = entry[(head+i) mod DEPTH]; unused slots carry don't-care data.
- Issue select: fire[i] = peek_valid[i] && issue_ok[i] && fire[i-1], with fire[-1] = 1. This is strict in-order; a blocked slot blocks all younger slots.
  - n_out = popcount(fire); head advances by n_out.
  - count_next = count + n_in - n_out; it never exceeds DEPTH and never goes below 0.
- Issue register: iss_valid <= fire, iss_data[i] <= peek_data[i] when fire[i] (otherwise hold value).
  - Latency: decode edge → peekable next cycle → iss_valid the cycle after that. Minimum 2 cycles from in_valid to iss_valid.
- Empty: peek_valid all 0; nothing fires; enqueue still allowed.
- Full or nearly full (count > DEPTH-FETCH_W): in_ready=0 and stall=1; issue continues. in_ready rises the cycle after count drops.
- Flush: next edge sets head=tail=count=0 and iss_valid=0. Flush overrides a same-cycle enqueue and issue; in_ready is unaffected combinationally.
- Reset (rst=1 at an edge), including mid-operation: head=tail=count=0, iss_valid=0, iss_data=0, entries need no reset. With count=0 after reset, occupancy=0, peek_valid=0, in_ready=1 and stall=0.
- Simultaneous enqueue and issue in one cycle is legal and both take effect.

Test Plan (defaults FETCH_W=2, ISSUE_W=2, DEPTH=4, DATA_W=32):
- Reset then idle:
  - rst=1 for one edge while count was 3 → occupancy=0, peek_valid=00, iss_valid=00, in_ready=1, all held until first enqueue.
- Pipeline latency:
  - enqueue {0xA0 slot0, 0xA1 slot1} at cycle 0 with issue_ok=11 → peek at cycle 1, iss_valid=11 with iss_data {0xA0,0xA1} at cycle 2, occupancy back to 0.
- In-order blocking:
  - queue holds 0xB0,0xB1,0xB2; issue_ok=10 (slot0 blocked, slot1 ok) → no issue, iss_valid=00, occupancy=3.
  - next cycle issue_ok=01 → only 0xB0 issues, head advances 1.
- Full and stall:
  - enqueue pairs 0xC0..0xC3 with issue_ok=00 → occupancy=4, in_ready=0, stall=1, further in_valid ignored.
  - issue_ok=11 for one cycle → 0xC0,0xC1 issue, in_ready=1 next cycle.
- Wrap-around:
  - 10 enqueue pairs with continuous issue_ok=11 → iss_data sequence matches input order exactly, across at least two head/tail wraps.
- Flush races:
  - flush=1 in the same cycle as an enqueue of 0xD0,0xD1 and issue_ok=11 with 2 entries queued → iss_valid=00 next cycle, occupancy=0, 0xD0/0xD1 never issue.
